scheduler_mem_issuer: RTL and testbench
=======================================

Name: scheduler_mem_issuer

Overview:
- Downstream stage of the scheduler request buffer. It takes the buffer's head request (address, store data, read/write type) and drives a single-outstanding request/grant/response handshake to the memory port.
- On completion it pulses request_done back to the buffer and returns the completed address as a callback. Reads also return their load data.
- A per-request watchdog counter bounds memory latency and raises a sticky error flag when it expires.

Parameters:
- WORD_W, 32, width of address, store data and load data.
- TIMEOUT, 255, maximum cycles spent in ISSUE+WAIT before the request is abandoned.
- TO_W, 8, width of the watchdog counter; TIMEOUT must be less than 2**TO_W.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- req_addr  in  WORD_W  head request address (ramaddr_rq).
- req_wdata  in  WORD_W  head store data (ramstore_rq).
- req_ren  in  1  head is a read (ramREN_curr).
- req_wen  in  1  head is a write (ramWEN_curr).
- request_done  out  1  one-cycle pulse; the buffer advances its read pointer.
- memaddr_callback  out  WORD_W  address of the request completing this cycle.
- load_data  out  WORD_W  read return data.
- load_valid  out  1  one-cycle pulse, qualifies load_data.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  WORD_W  memory address.
- mem_wdata  out  WORD_W  memory store data.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  WORD_W  read data.
- err_clr  in  1  clears the sticky error flags.
- timeout_err  out  1  sticky; a request timed out.
- illegal_err  out  1  sticky; head had req_ren and req_wen both set.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset: RST is synchronous and active-high; CLK is the only clock.
  - While RST is sampled high: FSM goes to IDLE; all outputs go to 0; latched request registers, watchdog and error flags clear.
  - RST asserted mid-transaction abandons the transaction without a request_done pulse. A late mem_gnt or mem_rvalid after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If req_ren XOR req_wen: latch addr, wdata and type into internal registers; clear the watchdog; go to ISSUE.
  - If req_ren AND req_wen: set illegal_err; latch the address; go to DONE without any memory access.
  - Otherwise stay in IDLE.
- ISSUE:
  - mem_req=1; mem_we, mem_addr and mem_wdata come from the latched registers and stay stable until mem_gnt.
  - mem_gnt=1 on a write: go to DONE.
  - mem_gnt=1 on a read: go to WAIT. If mem_rvalid is also 1 in the same cycle, capture mem_rdata and go directly to DONE.
  - mem_req drops the cycle after the grant.
- WAIT:
  - mem_req=0.
  - On mem_rvalid=1: capture mem_rdata into the load register and go to DONE.
- DONE:
  - request_done=1 for exactly one cycle; memaddr_callback = latched address.
  - load_valid=1 only for a successful read, with load_data = captured data.
  - Always go to IDLE next.
  - The IDLE cycle after DONE lets the buffer's head update. A stale head is never re-issued, so the minimum spacing between request_done pulses is 3 cycles.
- Latency: a write granted immediately gives request_done 2 cycles after the head appears; a read with zero-cycle response also gives 2 cycles.
- Watchdog:
  - Increments every cycle spent in ISSUE or WAIT; resets on entry to ISSUE.
  - When it equals TIMEOUT while still waiting: set timeout_err, go to DONE with load_valid=0, force mem_req low.
  - A grant or rvalid arriving in the same cycle as expiry wins; no timeout is flagged in that case.
- Outside DONE: memaddr_callback, load_data, request_done and load_valid are 0.
- Errors: timeout_err and illegal_err are sticky and cleared only by err_clr or RST. A set event in the same cycle as err_clr takes priority (the flag stays 1).
- Head changes: changes on req_* while busy are ignored; the latched copy is authoritative.
- busy = (state != IDLE).

Test Plan:
- Write addr=0x100, wdata=0xDEADBEEF, mem_gnt held high → mem_req for 1 cycle with mem_we=1; request_done and callback=0x100 two cycles after the head appears; load_valid=0.
- Read addr=0x200, gnt after 3 cycles, rvalid with 0x12345678 after 4 more → mem_req high for 4 cycles; load_valid=1 with load_data=0x12345678 in DONE; callback=0x200.
- Read with TIMEOUT=10 and mem_gnt never asserted → request_done at cycle 11 after ISSUE entry; timeout_err=1 and stays high until err_clr.
- Head has req_ren=req_wen=1 → no mem_req; illegal_err=1; request_done pulses with the callback address.
- Back-to-back write then read → both complete in order; request_done pulses are ≥3 cycles apart; the second request is not issued until the IDLE cycle.
- RST asserted in WAIT, then mem_rvalid arrives → no load_valid and no request_done; all outputs 0; busy=0.

Source files
------------

// File: rtl/scheduler_mem_issuer.sv
// Memory issuer for the scheduler request buffer head.
// Single outstanding req/gnt/rvalid transaction with a watchdog and sticky errors.
module scheduler_mem_issuer #(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic              req_ren,
    input  logic              req_wen,
    output logic              request_done,
    output logic [WORD_W-1:0] memaddr_callback,
    output logic [WORD_W-1:0] load_data,
    output logic              load_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              err_clr,
    output logic              timeout_err,
    output logic              illegal_err,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state;
    state_t            state_n;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] rdata_q;
    logic              we_q;
    logic              ok_q;
    logic [TO_W-1:0]   wd_q;
    logic              latch;
    logic              il_set;
    logic              to_set;
    logic              cap;
    logic              expired;

    // Next-state decode; grant/rvalid take priority over watchdog expiry
    always_comb begin
        state_n = state;
        latch   = 1'b0;
        il_set  = 1'b0;
        to_set  = 1'b0;
        cap     = 1'b0;
        expired = (wd_q >= TO_W'(TIMEOUT));
        unique case (state)
            IDLE: begin
                if (req_ren ^ req_wen) begin
                    latch   = 1'b1;
                    state_n = ISSUE;
                end else if (req_ren & req_wen) begin
                    il_set  = 1'b1;
                    state_n = DONE;
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    if (we_q) begin
                        state_n = DONE;
                    end else if (mem_rvalid) begin
                        cap     = 1'b1;
                        state_n = DONE;
                    end else begin
                        state_n = WAIT;
                    end
                end else if (expired) begin
                    to_set  = 1'b1;
                    state_n = DONE;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    cap     = 1'b1;
                    state_n = DONE;
                end else if (expired) begin
                    to_set  = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    // Latched request, load capture, saturating watchdog and sticky errors
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            we_q        <= 1'b0;
            ok_q        <= 1'b0;
            wd_q        <= '0;
            timeout_err <= 1'b0;
            illegal_err <= 1'b0;
        end else begin
            if (latch || il_set) addr_q <= req_addr;
            if (latch) begin
                wdata_q <= req_wdata;
                we_q    <= req_wen;
                wd_q    <= '0;
            end else if ((state == ISSUE || state == WAIT) && wd_q != '1) begin
                wd_q <= wd_q + 1'b1;
            end
            if (state_n == DONE) ok_q <= cap;
            if (cap) rdata_q <= mem_rdata;
            timeout_err <= to_set | (timeout_err & ~err_clr);
            illegal_err <= il_set | (illegal_err & ~err_clr);
        end
    end

    assign mem_req          = (state == ISSUE);
    assign mem_we           = mem_req & we_q;
    assign mem_addr         = mem_req ? addr_q : '0;
    assign mem_wdata        = mem_req ? wdata_q : '0;
    assign request_done     = (state == DONE);
    assign memaddr_callback = request_done ? addr_q : '0;
    assign load_valid       = request_done & ok_q;
    assign load_data        = load_valid ? rdata_q : '0;
    assign busy             = (state != IDLE);

endmodule

// File: tb/tb_scheduler_mem_issuer.sv
// Scoreboard bench for scheduler_mem_issuer.
// Stimulus pushes expected completions; a negedge monitor pops and compares.
module tb_scheduler_mem_issuer;

    localparam int W = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [W-1:0]  req_addr = '0;
    logic [W-1:0]  req_wdata = '0;
    logic          req_ren = 1'b0;
    logic          req_wen = 1'b0;
    logic          request_done;
    logic [W-1:0]  memaddr_callback;
    logic [W-1:0]  load_data;
    logic          load_valid;
    logic          mem_req;
    logic          mem_we;
    logic [W-1:0]  mem_addr;
    logic [W-1:0]  mem_wdata;
    logic          mem_gnt = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [W-1:0]  mem_rdata = '0;
    logic          err_clr = 1'b0;
    logic          timeout_err;
    logic          illegal_err;
    logic          busy;

    scheduler_mem_issuer #(.WORD_W(W), .TIMEOUT(10), .TO_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ren(req_ren), .req_wen(req_wen),
        .request_done(request_done), .memaddr_callback(memaddr_callback),
        .load_data(load_data), .load_valid(load_valid),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .err_clr(err_clr), .timeout_err(timeout_err),
        .illegal_err(illegal_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] addr;
        logic         lv;
        logic [W-1:0] ld;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    int           n_chk = 0;
    int           n_pass = 0;
    int           cyc = 0;
    int           req_cnt = 0;
    int           last_done = -100;
    bit           started = 1'b0;
    logic         exp_we = 1'b0;
    logic [W-1:0] exp_addr = '0;
    logic [W-1:0] exp_wdata = '0;

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(logic [W-1:0] a, logic lv, logic [W-1:0] ld, int c);
        exp_t e;
        e.addr = a;
        e.lv   = lv;
        e.ld   = ld;
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic wait_done(int lim);
        int n = 0;
        while (n < lim) begin
            @(negedge CLK);
            if (request_done) break;
            n++;
        end
        check("wait_done_bound", W'(n < lim), W'(1));
        step();
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (started) begin
            if (mem_req) begin
                req_cnt++;
                check("mem_we", W'(mem_we), W'(exp_we));
                check("mem_addr", mem_addr, exp_addr);
                if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
            end
            if (request_done) begin
                if (q.size() == 0) begin
                    check("done_with_empty_sb", W'(request_done), W'(0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("callback", memaddr_callback, e.addr);
                    check("load_valid", W'(load_valid), W'(e.lv));
                    check("load_data", load_data, e.ld);
                    check("done_cycle", W'(cyc), W'(e.cyc));
                end
                check("done_spacing", W'(cyc - last_done >= 3), W'(1));
                last_done = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        step();
        started = 1'b1;
        step();
        @(negedge CLK);
        check("rst_busy", W'(busy), W'(0));
        check("rst_mem_req", W'(mem_req), W'(0));
        check("rst_done", W'(request_done), W'(0));
        check("rst_terr", W'(timeout_err), W'(0));
        check("rst_ierr", W'(illegal_err), W'(0));
        step();
        RST = 1'b0;
        step();

        // Write, grant held high
        req_cnt   = 0;
        t0        = cyc;
        exp_we    = 1'b1;
        exp_addr  = 32'h100;
        exp_wdata = 32'hDEADBEEF;
        req_addr  = 32'h100;
        req_wdata = 32'hDEADBEEF;
        req_wen   = 1'b1;
        mem_gnt   = 1'b1;
        push(32'h100, 1'b0, '0, t0 + 2);
        wait_done(20);
        req_wen = 1'b0;
        mem_gnt = 1'b0;
        check("wr_req_cycles", W'(req_cnt), W'(1));
        step();

        // Read, grant on 4th issue cycle, rvalid 4 cycles later
        req_cnt  = 0;
        t0       = cyc;
        exp_we   = 1'b0;
        exp_addr = 32'h200;
        req_addr = 32'h200;
        req_ren  = 1'b1;
        push(32'h200, 1'b1, 32'h12345678, t0 + 9);
        step();
        step();
        check("rd_busy", W'(busy), W'(1));
        step();
        step();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        step();
        step();
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        req_ren    = 1'b0;
        step();
        check("rd_req_cycles", W'(req_cnt), W'(4));
        step();

        // Read that times out; head changes while busy are ignored
        req_cnt  = 0;
        t0       = cyc;
        exp_addr = 32'h300;
        req_addr = 32'h300;
        req_ren  = 1'b1;
        push(32'h300, 1'b0, '0, t0 + 12);
        step();
        req_addr = 32'h999;
        req_ren  = 1'b0;
        wait_done(30);
        check("to_req_cycles", W'(req_cnt), W'(11));
        @(negedge CLK);
        check("to_err_set", W'(timeout_err), W'(1));
        step();
        step();
        @(negedge CLK);
        check("to_err_sticky", W'(timeout_err), W'(1));
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        @(negedge CLK);
        check("to_err_clr", W'(timeout_err), W'(0));
        step();

        // Illegal head: both read and write
        req_cnt  = 0;
        t0       = cyc;
        req_addr = 32'h400;
        req_ren  = 1'b1;
        req_wen  = 1'b1;
        push(32'h400, 1'b0, '0, t0 + 1);
        step();
        req_ren = 1'b0;
        req_wen = 1'b0;
        step();
        @(negedge CLK);
        check("il_no_req", W'(req_cnt), W'(0));
        check("il_err_set", W'(illegal_err), W'(1));
        check("il_to_clear", W'(timeout_err), W'(0));
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        @(negedge CLK);
        check("il_err_clr", W'(illegal_err), W'(0));
        step();

        // Back-to-back write then read with zero-latency memory
        req_cnt    = 0;
        t0         = cyc;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        exp_we     = 1'b1;
        exp_addr   = 32'h500;
        exp_wdata  = 32'h0000AAAA;
        req_addr   = 32'h500;
        req_wdata  = 32'h0000AAAA;
        req_wen    = 1'b1;
        push(32'h500, 1'b0, '0, t0 + 2);
        step();
        step();
        step();
        exp_we   = 1'b0;
        exp_addr = 32'h600;
        req_addr = 32'h600;
        req_wen  = 1'b0;
        req_ren  = 1'b1;
        push(32'h600, 1'b1, 32'hCAFEF00D, t0 + 5);
        step();
        step();
        step();
        req_ren    = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        check("b2b_req_cycles", W'(req_cnt), W'(2));
        step();

        // Reset while waiting for read data
        exp_addr = 32'h700;
        req_addr = 32'h700;
        req_ren  = 1'b1;
        step();
        mem_gnt = 1'b1;
        req_ren = 1'b0;
        step();
        mem_gnt = 1'b0;
        @(negedge CLK);
        check("rst_wait_busy", W'(busy), W'(1));
        step();
        RST = 1'b1;
        step();
        RST        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55555555;
        @(negedge CLK);
        check("post_rst_busy", W'(busy), W'(0));
        check("post_rst_mem_req", W'(mem_req), W'(0));
        check("post_rst_addr", mem_addr, '0);
        check("post_rst_done", W'(request_done), W'(0));
        check("post_rst_lv", W'(load_valid), W'(0));
        check("post_rst_ld", load_data, '0);
        check("post_rst_cb", memaddr_callback, '0);
        step();
        step();
        mem_rvalid = 1'b0;
        @(negedge CLK);
        check("late_rvalid_ignored", W'(busy), W'(0));
        step();

        check("sb_empty", W'(q.size()), W'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
